// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int TIMEOUT_DEF    = 15;

    // Wide enough for the full 1..255 timeout range.
    localparam int CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Command latched at accept time; id is the granted requester.
    typedef struct packed {
        logic                      wr;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] wdata;
        logic                      id;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way combinational round-robin picker.
// A lone valid always wins; with both valid, the requester that was not
// served last wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       id
);

    // Pick the winner from the valids and the previous grant.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        grant = 2'b00;
        id    = 1'b0;
        unique case (valid)
            2'b01: begin
                grant = 2'b01;
                id    = 1'b0;
            end
            2'b10: begin
                grant = 2'b10;
                id    = 1'b1;
            end
            2'b11: begin
                id    = ~last_grant;
                grant = last_grant ? 2'b01 : 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer for two requesters in front of a
// single-port RAM. One command is in flight at a time:
//   IDLE -> ISSUE (one-cycle strobe) -> WAIT (response or timeout) -> RESP.
// All memory-side and response outputs come straight from flops; only the
// ready handshakes are combinational.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp0_err,

    input  logic                  req1_valid,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  rsp1_err,

    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_response
);

    // The latched command uses the package widths; overriding ADDR_WIDTH or
    // DATA_WIDTH away from them requires the package defaults to follow.
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

    arb_state_t state_q, state_d;
    mem_cmd_t   cmd_q, cmd_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic       last_grant_q, last_grant_d;
    logic       mem_wr_q, mem_wr_d;
    logic       mem_rd_q, mem_rd_d;
    logic [1:0] rsp_valid_q, rsp_valid_d;
    logic [1:0] rsp_err_q, rsp_err_d;
    logic [1:0][DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [1:0] req_valid;
    logic [1:0] grant;
    logic       win_id;
    logic       accept_en;

    assign req_valid = {req1_valid, req0_valid};

    rr_arb2 u_rr_arb2 (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .id         (win_id)
    );

    // Ready is only offered in IDLE and never while reset is held, so no
    // requester believes a command was taken by a design that is in reset.
    assign accept_en  = reset && (state_q == IDLE);
    assign req0_ready = accept_en && grant[0];
    assign req1_ready = accept_en && grant[1];

    // Next-state, command latch, counter and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        mem_wr_d     = 1'b0;
        mem_rd_d     = 1'b0;
        rsp_valid_d  = '0;
        rsp_err_d    = '0;
        rsp_rdata_d  = '0;
        cnt_inc      = cnt_q + CNT_WIDTH'(1);

        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    cmd_d.id    = win_id;
                    cmd_d.wr    = win_id ? req1_wr    : req0_wr;
                    cmd_d.addr  = win_id ? req1_addr  : req0_addr;
                    cmd_d.wdata = win_id ? req1_wdata : req0_wdata;
                    // Strobe flops load now so the strobe is visible during ISSUE.
                    mem_wr_d    = cmd_d.wr;
                    mem_rd_d    = ~cmd_d.wr;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end

            WAIT: begin
                // A response on the final WAIT cycle still beats the timeout.
                if (mem_response) begin
                    rsp_valid_d[cmd_q.id] = 1'b1;
                    rsp_rdata_d[cmd_q.id] = cmd_q.wr ? '0 : mem_rdata;
                    state_d               = RESP;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    rsp_valid_d[cmd_q.id] = 1'b1;
                    rsp_err_d[cmd_q.id]   = 1'b1;
                    state_d               = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            RESP: begin
                last_grant_d = cmd_q.id;
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; asynchronous reset discards any in-flight command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            mem_wr_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            mem_wr_q     <= mem_wr_d;
            mem_rd_q     <= mem_rd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    // Address and write data come from the latched command, so they stay
    // stable through WAIT and until the next accept.
    assign mem_wr     = mem_wr_q;
    assign mem_rd     = mem_rd_q;
    assign mem_addr   = cmd_q.addr;
    assign mem_wdata  = cmd_q.wdata;

    assign rsp0_valid = rsp_valid_q[0];
    assign rsp0_err   = rsp_err_q[0];
    assign rsp0_rdata = rsp_rdata_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp1_err   = rsp_err_q[1];
    assign rsp1_rdata = rsp_rdata_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A RAM responder with programmable
// latency sits on the memory side; a transaction-level model predicts, for
// every accepted command, which port responds, when, and with what data.
module tb_mem_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        reset;
    logic [1:0]  v, w;
    logic [3:0]  a [2];
    logic [31:0] d [2];
    logic [1:0]  r;
    logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_wr, mem_rd, mem_response;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (v[0]),
        .req0_wr      (w[0]),
        .req0_addr    (a[0]),
        .req0_wdata   (d[0]),
        .req0_ready   (r[0]),
        .rsp0_valid   (rsp0_valid),
        .rsp0_rdata   (rsp0_rdata),
        .rsp0_err     (rsp0_err),
        .req1_valid   (v[1]),
        .req1_wr      (w[1]),
        .req1_addr    (a[1]),
        .req1_wdata   (d[1]),
        .req1_ready   (r[1]),
        .rsp1_valid   (rsp1_valid),
        .rsp1_rdata   (rsp1_rdata),
        .rsp1_err     (rsp1_err),
        .mem_wr       (mem_wr),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_response (mem_response)
    );

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [16];
    logic        model_last;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ram_lat = 1;
    int          inject_req = 0;
    int          inject_done = 0;
    logic [31:0] ram [16];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed time %0t, required completion earlier", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", name, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"},  {r, rsp1_valid, rsp0_valid, rsp1_err, rsp0_err, mem_wr, mem_rd}, 0);
        check({tag, "_addr"},  64'(mem_addr), 0);
        check({tag, "_wdata"}, 64'(mem_wdata), 0);
        check({tag, "_rdata"}, {rsp1_rdata, rsp0_rdata}, 0);
    endtask

    // RAM stand-in: sees the strobe, answers ram_lat cycles later (0 = never).
    initial begin : ram_responder
        int          cd;
        logic [31:0] rd_hold;
        cd = 0;
        rd_hold = '0;
        mem_response = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        forever begin
            @(negedge clk);
            mem_response = 1'b0;
            mem_rdata = $urandom;
            if (!reset) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        mem_response = 1'b1;
                        mem_rdata = rd_hold;
                    end
                end
                if (inject_done != inject_req) begin
                    inject_done++;
                    mem_response = 1'b1;
                end
                if (mem_wr) begin
                    ram[mem_addr] = mem_wdata;
                    rd_hold = $urandom;
                    cd = ram_lat;
                end else if (mem_rd) begin
                    rd_hold = ram[mem_addr];
                    cd = ram_lat;
                end
            end
        end
    end

    // Response scoreboard: every rsp pulse must match the oldest prediction.
    initial forever begin : monitor
        exp_t        e;
        logic [1:0]  rv;
        logic [1:0]  re;
        logic [31:0] rd;
        @(negedge clk);
        #2;
        rv = {rsp1_valid, rsp0_valid};
        re = {rsp1_err, rsp0_err};
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                if (rv[p]) begin
                    rd = (p == 0) ? rsp0_rdata : rsp1_rdata;
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp_port", 64'(p), 64'hFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_port",  64'(p), 64'(e.port));
                        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
                        check("rsp_rdata", 64'(rd), 64'(e.rdata));
                        check("rsp_err",   64'(re[p]), 64'(e.err));
                    end
                end
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                check("rsp_missing_cycle", 64'(cyc), 64'(exp_q[0].cyc));
                void'(exp_q.pop_front());
            end
        end
    end

    // Prediction for a command accepted now on port p.
    task automatic push_expected(input int p);
        exp_t e;
        e.port  = p;
        e.err   = (ram_lat == 0) || (ram_lat > TIMEOUT);
        e.rdata = (!w[p] && !e.err) ? model_mem[a[p]] : 32'h0;
        e.cyc   = cyc + 2 + (e.err ? TIMEOUT : ram_lat);
        exp_q.push_back(e);
        if (w[p]) model_mem[a[p]] = d[p];
        model_last = p[0];
    endtask

    task automatic set_req(input int p, input logic wr, input logic [3:0] addr, input logic [31:0] wdata);
        v[p] = 1'b1;
        w[p] = wr;
        a[p] = addr;
        d[p] = wdata;
    endtask

    // Present one command on port p, wait for its accept, optionally check the strobe.
    task automatic issue(input int p, input logic wr, input logic [3:0] addr,
                         input logic [31:0] wdata, input bit chk_strobe);
        bit acc;
        int exp_p;
        acc = 0;
        @(negedge clk);
        set_req(p, wr, addr, wdata);
        for (int i = 0; i < 40 && !acc; i++) begin
            #1;
            if (r[p]) acc = 1;
            else @(negedge clk);
        end
        check("accept_seen", 64'(acc), 1);
        if (acc) begin
            exp_p = 1 - p;
            check("other_ready_low", 64'(r[exp_p]), 0);
            push_expected(p);
        end
        @(negedge clk);
        v[p] = 1'b0;
        if (chk_strobe) begin
            #1;
            check("strobe_wr",    64'(mem_wr), 64'(wr));
            check("strobe_rd",    64'(mem_rd), 64'(!wr));
            check("strobe_addr",  64'(mem_addr), 64'(addr));
            check("strobe_wdata", 64'(mem_wdata), 64'(wdata));
            @(negedge clk);
            #1;
            check("strobe_one_cycle", 64'({mem_wr, mem_rd}), 0);
            check("addr_held",        64'(mem_addr), 64'(addr));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
        check("drain_pending", 64'(exp_q.size()), 0);
        @(negedge clk);
    endtask

    initial begin : stimulus
        int   pend [2];
        int   upd;
        int   prev;
        int   p;
        int   exp_p;
        bit   seen;
        logic [31:0] data;

        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        model_last = 1'b1;
        reset = 1'b0;
        v = 2'b11;
        w = '0;
        a[0] = '0; a[1] = '0;
        d[0] = '0; d[1] = '0;

        // Reset state, with both requesters asking.
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        v = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Write 0xDEADBEEF to addr 5 from port 0, one-cycle RAM latency.
        ram_lat = 1;
        issue(0, 1'b1, 4'd5, 32'hDEAD_BEEF, 1);
        drain();

        // Read addr 5 back through port 1.
        issue(1, 1'b0, 4'd5, 32'h0, 1);
        drain();

        // Both ports requesting continuously: strict alternation, accepts 4 cycles apart.
        ram_lat = 1;
        pend[0] = 4;
        pend[1] = 4;
        upd = -1;
        prev = -1;
        @(negedge clk);
        set_req(0, 1'($urandom), 4'($urandom), $urandom);
        set_req(1, 1'($urandom), 4'($urandom), $urandom);
        for (int i = 0; i < 200 && (pend[0] + pend[1] > 0 || upd >= 0); i++) begin
            if (i > 0) @(negedge clk);
            if (upd >= 0) begin
                if (pend[upd] > 0) set_req(upd, 1'($urandom), 4'($urandom), $urandom);
                else v[upd] = 1'b0;
                upd = -1;
            end
            #1;
            if (r != 2'b00) begin
                p = r[1] ? 1 : 0;
                if (v == 2'b11) exp_p = model_last ? 0 : 1;
                else exp_p = v[1] ? 1 : 0;
                check("grant_order", 64'(p), 64'(exp_p));
                check("ready_onehot", 64'(r), p ? 2'b10 : 2'b01);
                if (prev >= 0) check("accept_gap", 64'(cyc - prev), 4);
                prev = cyc;
                push_expected(p);
                pend[p]--;
                upd = p;
            end
        end
        check("fair_remaining", 64'(pend[0] + pend[1]), 0);
        drain();

        // RAM never answers: error response TIMEOUT WAIT cycles after the strobe.
        ram_lat = 0;
        issue(0, 1'b0, 4'd5, 32'h0, 1);
        drain();
        // A stray response in IDLE must do nothing.
        inject_req++;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (rsp0_valid || rsp1_valid || mem_wr || mem_rd) seen = 1;
        end
        check("late_rsp_ignored", 64'(seen), 0);
        ram_lat = 2;
        issue(1, 1'b0, 4'd5, 32'h0, 0);
        drain();

        // Reset during WAIT of a write to addr 3: outputs clear, no response later.
        ram_lat = 0;
        issue(0, 1'b1, 4'd3, $urandom, 0);
        repeat (3) @(negedge clk);
        #3 reset = 1'b0;
        #1 check_all_zero("rst_wait");
        exp_q.delete();
        model_last = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            #1;
            if (rsp0_valid || rsp1_valid) seen = 1;
        end
        check("no_rsp_after_reset", 64'(seen), 0);

        // Reset during ISSUE: the strobe drops without waiting for a clock.
        issue(1, 1'b1, 4'd7, $urandom, 1'b0);
        #1 check("issue_strobe_up", 64'(mem_wr), 1);
        #2 reset = 1'b0;
        #1 check("strobe_async_drop", 64'(mem_wr), 0);
        check_all_zero("rst_issue");
        exp_q.delete();
        model_last = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Address sweep: write 0..15 then read back via alternating ports.
        for (int i = 0; i < 16; i++) begin
            ram_lat = (i == 15) ? TIMEOUT : int'($urandom_range(1, 6));
            data = $urandom;
            issue(i % 2, 1'b1, 4'(i), data, 0);
            drain();
        end
        for (int i = 0; i < 16; i++) begin
            ram_lat = (i == 15) ? TIMEOUT : int'($urandom_range(1, 6));
            issue((i + 1) % 2, 1'b0, 4'(i), 32'h0, 0);
            drain();
        end

        // Random single-port traffic, including occasional timeouts.
        for (int i = 0; i < 12; i++) begin
            ram_lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 6));
            issue(int'($urandom_range(0, 1)), 1'($urandom), 4'($urandom), $urandom, 1);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
